// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: tracks in-flight destinations after ID, selects forwarding
// sources per operand and raises a load-use stall until the load becomes forwardable.
module pipe_hazard_unit #(
  parameter int DEPTH    = 3,
  parameter int XLEN     = 32,
  parameter int REGW     = 5,
  parameter int LD_STAGE = 1,
  parameter int NOWR_REG = 30
) (
  input  logic                  clk,
  input  logic                  rst_sync,
  input  logic                  issue_valid,
  input  logic [REGW-1:0]       issue_rd,
  input  logic                  issue_regwr,
  input  logic                  issue_memrd,
  input  logic                  issue_rpzero,
  input  logic                  kill,
  input  logic [REGW-1:0]       src_rs,
  input  logic [REGW-1:0]       src_rt,
  input  logic                  src_rs_used,
  input  logic                  src_rt_used,
  input  logic [DEPTH*XLEN-1:0] stage_data,
  output logic                  stall,
  output logic [3:0]            fwd_rs_sel,
  output logic [3:0]            fwd_rt_sel,
  output logic [XLEN-1:0]       fwd_rs_data,
  output logic [XLEN-1:0]       fwd_rt_data,
  output logic [15:0]           stall_count
);

  logic [DEPTH-1:0] v_r;
  logic [DEPTH-1:0] wen_r;
  logic [DEPTH-1:0] ld_r;
  logic [REGW-1:0]  rd_r [DEPTH];

  logic [DEPTH-1:0] rs_match_s;
  logic [DEPTH-1:0] rt_match_s;
  logic [3:0]       rs_sel_s;
  logic [3:0]       rt_sel_s;
  logic             rs_ld_s;
  logic             rt_ld_s;
  logic [XLEN-1:0]  rs_data_s;
  logic [XLEN-1:0]  rt_data_s;
  logic             issue_wen_s;
  logic             capture_s;
  logic             stall_s;

  // Per-stage source match; wen already excludes R0 and NOWR_REG
  always_comb begin
    rs_match_s = '0;
    rt_match_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      rs_match_s[k] = v_r[k] & wen_r[k] & (rd_r[k] == src_rs) & src_rs_used;
      rt_match_s[k] = v_r[k] & wen_r[k] & (rd_r[k] == src_rt) & src_rt_used;
    end
  end

  // Youngest match wins: scan oldest to youngest so lower stages overwrite
  always_comb begin
    rs_sel_s = 4'd0;
    rt_sel_s = 4'd0;
    rs_ld_s  = 1'b0;
    rt_ld_s  = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rs_sel_s = rs_match_s[k] ? 4'(k + 1) : rs_sel_s;
      rs_ld_s  = rs_match_s[k] ? ld_r[k]   : rs_ld_s;
      rt_sel_s = rt_match_s[k] ? 4'(k + 1) : rt_sel_s;
      rt_ld_s  = rt_match_s[k] ? ld_r[k]   : rt_ld_s;
    end
  end

  // Forwarded data mux; zero when the register file is selected
  always_comb begin
    rs_data_s = '0;
    rt_data_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      rs_data_s = (rs_sel_s == 4'(k + 1)) ? stage_data[k*XLEN +: XLEN] : rs_data_s;
      rt_data_s = (rt_sel_s == 4'(k + 1)) ? stage_data[k*XLEN +: XLEN] : rt_data_s;
    end
  end

  // Load-use stall: winning entry is a load still before LD_STAGE (sel = k+1 <= LD_STAGE)
  always_comb begin
    stall_s     = issue_valid & ~kill &
                  ((rs_ld_s & (rs_sel_s != 4'd0) & (rs_sel_s <= 4'(LD_STAGE))) |
                   (rt_ld_s & (rt_sel_s != 4'd0) & (rt_sel_s <= 4'(LD_STAGE))));
    issue_wen_s = issue_regwr & ~issue_rpzero & (issue_rd != '0) &
                  (issue_rd != REGW'(NOWR_REG));
    capture_s   = issue_valid & ~kill & ~stall_s;
  end

  assign stall       = stall_s;
  assign fwd_rs_sel  = rs_sel_s;
  assign fwd_rt_sel  = rt_sel_s;
  assign fwd_rs_data = rs_data_s;
  assign fwd_rt_data = rt_data_s;

  // Stage tracker shift register and saturating stall counter
  always_ff @(posedge clk or posedge rst_sync) begin
    if (rst_sync) begin
      v_r         <= '0;
      wen_r       <= '0;
      ld_r        <= '0;
      stall_count <= 16'd0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_r[k] <= '0;
      end
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        v_r[k]   <= v_r[k-1];
        wen_r[k] <= wen_r[k-1];
        ld_r[k]  <= ld_r[k-1];
        rd_r[k]  <= rd_r[k-1];
      end
      v_r[0]   <= capture_s;
      wen_r[0] <= issue_wen_s;
      ld_r[0]  <= issue_memrd;
      rd_r[0]  <= issue_rd;
      if (stall_s && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end else begin
        stall_count <= stall_count;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed and random issue streams against
// an instruction-history model, plus a deep-pipeline instance for counter saturation.
module tb_pipe_hazard_unit;

  localparam int XLEN  = 32;
  localparam int REGW  = 5;
  localparam int DEPTH = 3;
  localparam int LDS   = 1;
  localparam int SDEP  = 8;
  localparam int SLDS  = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_sync;
  logic                  issue_valid, issue_regwr, issue_memrd, issue_rpzero, kill;
  logic [REGW-1:0]       issue_rd, src_rs, src_rt;
  logic                  src_rs_used, src_rt_used;
  logic [DEPTH*XLEN-1:0] stage_data;
  logic                  stall;
  logic [3:0]            fwd_rs_sel, fwd_rt_sel;
  logic [XLEN-1:0]       fwd_rs_data, fwd_rt_data;
  logic [15:0]           stall_count;

  logic                  s_issue_valid;
  logic [REGW-1:0]       s_issue_rd, s_src_rs;
  logic [SDEP*XLEN-1:0]  s_stage_data;
  logic                  s_stall;
  logic [3:0]            s_fwd_rs_sel, s_fwd_rt_sel;
  logic [XLEN-1:0]       s_fwd_rs_data, s_fwd_rt_data;
  logic [15:0]           s_stall_count;

  pipe_hazard_unit #(.DEPTH(DEPTH), .XLEN(XLEN), .REGW(REGW), .LD_STAGE(LDS), .NOWR_REG(30)) dut (
    .clk(clk), .rst_sync(rst_sync), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_regwr(issue_regwr), .issue_memrd(issue_memrd), .issue_rpzero(issue_rpzero),
    .kill(kill), .src_rs(src_rs), .src_rt(src_rt), .src_rs_used(src_rs_used),
    .src_rt_used(src_rt_used), .stage_data(stage_data), .stall(stall),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .fwd_rs_data(fwd_rs_data),
    .fwd_rt_data(fwd_rt_data), .stall_count(stall_count));

  pipe_hazard_unit #(.DEPTH(SDEP), .XLEN(XLEN), .REGW(REGW), .LD_STAGE(SLDS), .NOWR_REG(30)) u_sat (
    .clk(clk), .rst_sync(rst_sync), .issue_valid(s_issue_valid), .issue_rd(s_issue_rd),
    .issue_regwr(1'b1), .issue_memrd(1'b1), .issue_rpzero(1'b0), .kill(1'b0),
    .src_rs(s_src_rs), .src_rt(5'd0), .src_rs_used(1'b1), .src_rt_used(1'b0),
    .stage_data(s_stage_data), .stall(s_stall), .fwd_rs_sel(s_fwd_rs_sel),
    .fwd_rt_sel(s_fwd_rt_sel), .fwd_rs_data(s_fwd_rs_data), .fwd_rt_data(s_fwd_rt_data),
    .stall_count(s_stall_count));

  // Reference model: hist[a] is the instruction that entered EX a cycles ago
  typedef struct { bit v; int rd; bit wen; bit ld; } inst_t;
  inst_t hist[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_cnt = 0;
  bit    exp_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic void lookup(input int s, input bit used, output int sel, output bit ld);
    sel = 0;
    ld  = 1'b0;
    if (used) begin
      for (int a = 0; a < hist.size(); a++) begin
        if (sel == 0 && hist[a].v && hist[a].wen && hist[a].rd == s) begin
          sel = a + 1;
          ld  = hist[a].ld;
        end
      end
    end
  endfunction

  task automatic drive(input bit iv, input int rd, input bit wr, input bit ld, input bit rpz,
                       input bit kl, input int rs, input int rt, input bit rsu, input bit rtu);
    @(negedge clk);
    issue_valid = iv; issue_rd = REGW'(rd); issue_regwr = wr; issue_memrd = ld;
    issue_rpzero = rpz; kill = kl; src_rs = REGW'(rs); src_rt = REGW'(rt);
    src_rs_used = rsu; src_rt_used = rtu;
    stage_data = {$urandom, $urandom, $urandom};
  endtask

  // Check combinational outputs against the model, clock once, update model, check counter
  task automatic check_step(input string tag);
    int    ssel, tsel;
    bit    sld, tld;
    logic [XLEN-1:0] sd, td;
    inst_t n;
    #1;
    lookup(int'(src_rs), src_rs_used, ssel, sld);
    lookup(int'(src_rt), src_rt_used, tsel, tld);
    exp_stall = issue_valid && !kill && ((sld && ssel <= LDS) || (tld && tsel <= LDS));
    sd = (ssel == 0) ? '0 : stage_data[(ssel-1)*XLEN +: XLEN];
    td = (tsel == 0) ? '0 : stage_data[(tsel-1)*XLEN +: XLEN];
    chk({tag, "_stall"}, stall, exp_stall);
    chk({tag, "_rs_sel"}, fwd_rs_sel, ssel);
    chk({tag, "_rt_sel"}, fwd_rt_sel, tsel);
    chk({tag, "_rs_data"}, fwd_rs_data, sd);
    chk({tag, "_rt_data"}, fwd_rt_data, td);
    @(posedge clk);
    if (exp_stall && exp_cnt < 65535) exp_cnt++;
    n.v   = issue_valid && !kill && !exp_stall;
    n.rd  = int'(issue_rd);
    n.wen = issue_regwr && !issue_rpzero && issue_rd != 0 && issue_rd != 30;
    n.ld  = issue_memrd;
    hist.push_front(n);
    if (hist.size() > DEPTH) void'(hist.pop_back());
    #1;
    chk({tag, "_cnt"}, stall_count, exp_cnt);
  endtask

  function automatic int rnd_reg();
    int r;
    r = int'($urandom_range(0, 8));
    return (r == 8) ? 30 : r;
  endfunction

  initial begin
    int issued = 0;
    int cyc = 0;
    logic [4:0] cur = 5'd1;
    bit st;

    rst_sync = 1'b1;
    issue_valid = 1'b0; issue_rd = '0; issue_regwr = 1'b0; issue_memrd = 1'b0;
    issue_rpzero = 1'b0; kill = 1'b0; src_rs = 5'd5; src_rt = 5'd5;
    src_rs_used = 1'b1; src_rt_used = 1'b1; stage_data = '1;
    s_issue_valid = 1'b0; s_issue_rd = '0; s_src_rs = '0; s_stage_data = '0;
    #12;
    chk("rst_stall", stall, 1'b0);
    chk("rst_rs_sel", fwd_rs_sel, 4'd0);
    chk("rst_rs_data", fwd_rs_data, 32'd0);
    chk("rst_cnt", stall_count, 16'd0);
    @(negedge clk);
    rst_sync = 1'b0;

    // ALU producer then consumer forwards from EX
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); check_step("add_prod");
    drive(1, 0, 0, 0, 0, 0, 5, 0, 1, 0); check_step("add_use");
    // Load-use: one stall cycle, then forward from MEM
    drive(1, 7, 1, 1, 0, 0, 0, 0, 0, 0); check_step("lw_prod");
    drive(1, 0, 0, 0, 0, 0, 0, 7, 0, 1); check_step("lw_stall");
    drive(1, 0, 0, 0, 0, 0, 0, 7, 0, 1); check_step("lw_fwd");
    // Youngest of two writers wins
    drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0); check_step("dup_a");
    drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0); check_step("dup_b");
    drive(1, 0, 0, 0, 0, 0, 4, 4, 1, 1); check_step("dup_use");
    // Non-writing destinations never match
    drive(1, 0, 1, 1, 0, 0, 0, 0, 0, 0); check_step("nw_r0");
    drive(1, 30, 1, 1, 0, 0, 0, 0, 0, 0); check_step("nw_r30");
    drive(1, 9, 1, 1, 1, 0, 0, 0, 0, 0); check_step("nw_pz");
    drive(1, 0, 0, 0, 0, 0, 0, 30, 1, 1); check_step("nw_use0");
    drive(1, 0, 0, 0, 0, 0, 9, 30, 1, 1); check_step("nw_use9");
    // Kill beats load-use stall
    drive(1, 3, 1, 1, 0, 0, 0, 0, 0, 0); check_step("kill_prod");
    drive(1, 0, 0, 0, 0, 1, 3, 0, 1, 0); check_step("kill_use");
    drive(0, 0, 0, 0, 0, 0, 3, 0, 1, 0); check_step("kill_after");
    // Reset in the middle of a stall clears everything at once
    drive(1, 3, 1, 1, 0, 0, 0, 0, 0, 0); check_step("rst_prod");
    drive(1, 0, 0, 0, 0, 0, 3, 0, 1, 0);
    #1;
    chk("rst_mid_pre_stall", stall, 1'b1);
    rst_sync = 1'b1;
    #1;
    chk("rst_mid_stall", stall, 1'b0);
    chk("rst_mid_sel", fwd_rs_sel, 4'd0);
    chk("rst_mid_cnt", stall_count, 16'd0);
    hist.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst_sync = 1'b0;

    // Random stream over a small register set to provoke hazards
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 9) != 0), rnd_reg(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            rnd_reg(), rnd_reg(), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      check_step("rand");
    end

    // Saturation: chained loads on the deep instance stall 7 of every 8 cycles
    while (issued < 9364 && cyc < 80000) begin
      @(negedge clk);
      s_issue_valid = 1'b1;
      s_issue_rd    = cur;
      s_src_rs      = (cur == 5'd1) ? 5'd2 : 5'd1;
      #1;
      st = s_stall;
      @(posedge clk);
      cyc++;
      if (!st) begin
        issued++;
        cur = (cur == 5'd1) ? 5'd2 : 5'd1;
        if (issued == 3) begin
          #1;
          chk("sat_partial", s_stall_count, 16'd14);
        end
      end
    end
    #1;
    chk("sat_budget", issued, 9364);
    chk("sat_count", s_stall_count, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 Parameter DEPTH, default 3: tracked stages after ID (stage 0 = EX, DEPTH-1 = WB); legal range 2..8.
REQ-002 Parameter XLEN, default 32: data width.
REQ-003 Parameter REGW, default 5: register index width.
REQ-004 Parameter LD_STAGE, default 1: first stage index at which load data is forwardable (MEM); legal range 1..DEPTH-1.
REQ-005 Parameter NOWR_REG, default 30: register index never written, same as R0.
REQ-006 clk  in  1  clock, rising-edge.
REQ-007 rst_sync  in  1  reset, asynchronous, active-high.
REQ-008 issue_valid  in  1  ID holds a valid instruction attempting issue.
REQ-009 issue_rd / issue_regwr / issue_memrd / issue_rpzero  in  REGW/1/1/1  destination, writes-reg, is-load, predicate-false (suppresses write).
REQ-010 kill  in  1  ID instruction squashed this cycle (branch taken).
REQ-011 src_rs, src_rt  in  REGW each  ID source indices; src_rs_used, src_rt_used  in  1 each.
REQ-012 stage_data  in  DEPTH*XLEN  result bus per stage, slice k = stage k.
REQ-013 stall  out  1  hold PC and IF/ID, bubble into EX.
REQ-014 fwd_rs_sel, fwd_rt_sel  out  4  0 = register file, k+1 = stage k.
REQ-015 fwd_rs_data, fwd_rt_data  out  XLEN  selected stage_data slice, 0 when sel = 0.
REQ-016 stall_count  out  16  saturating count of stall cycles.

Function
REQ-017 Unit SHALL hold DEPTH entries {v, rd, wen, ld}; wen = issue_regwr & ~issue_rpzero & rd≠0 & rd≠NOWR_REG, computed at capture.
REQ-018 Every rising edge, entry k SHALL move to k+1; entry DEPTH-1 SHALL be discarded.
REQ-019 Entry 0 SHALL capture the ID instruction iff issue_valid & ~kill & ~stall; otherwise entry 0 SHALL become a bubble (v=0).
REQ-020 Source match: entry k matches source s iff v & wen & rd = s & s_used.
REQ-021 Youngest matching entry (lowest k) SHALL win; older matches ignored.
REQ-022 If the winning entry has ld=1 and k < LD_STAGE, stall SHALL be 1 (load-use); either source sufficient.
REQ-023 stall SHALL be forced 0 when kill=1 or issue_valid=0.
REQ-024 Otherwise fwd_x_sel SHALL be winning k+1, or 0 if no match.
REQ-025 stall and fwd outputs SHALL be combinational from entry state and ID inputs only; no dependency on stage_data except data muxing.
REQ-026 Source index 0 or NOWR_REG SHALL never match (wen=0 guarantees it).
REQ-027 Load-use stall SHALL persist exactly until the load reaches LD_STAGE: LD_STAGE-k cycles for load at stage k.
REQ-028 stall_count SHALL increment on each cycle stall=1, saturating at 16'hFFFF.
REQ-029 Simultaneous stall and kill: kill wins, stall=0, bubble inserted.

Reset
REQ-030 On rst_sync: all entries v=0, stall_count=0; thus stall=0, fwd_*_sel=0, fwd_*_data=0 immediately (asynchronous).
REQ-031 Reset mid-stall SHALL clear the stall in the same cycle; no stale entry survives.

Verification
REQ-032 Issue ADD rd=5, next cycle issue rs=5 -> fwd_rs_sel=1, fwd_rs_data=stage_data[0], stall=0.
REQ-033 Issue LW rd=7 (LD_STAGE=1), next cycle rt=7 -> stall=1 one cycle, then fwd_rt_sel=2, stall_count=1.
REQ-034 Issue rd=4 twice back-to-back, then rs=4 -> fwd_rs_sel=1 (youngest), not 2.
REQ-035 Issue writes to rd=0, rd=30, and predicate-false rd=9; consumer rs=0/30/9 -> fwd_rs_sel=0, stall=0.
REQ-036 LW rd=3 then consumer rs=3 with kill=1 -> stall=0, bubble enters EX; assert rst_sync mid-stall -> stall=0, stall_count=0 at once.
REQ-037 Force 65540 stall cycles -> stall_count holds 16'hFFFF.
